// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: hazard sequencer state
// encoding, register index width, NOP encoding and the load-use detect term.
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } ctrlState_e;

    // A load in EX whose destination feeds the instruction in ID; x0 never hazards.
    function automatic logic loadUseHazard(
        input logic              exMemRead,
        input logic [REG_AW-1:0] exRd,
        input logic [REG_AW-1:0] rs1,
        input logic [REG_AW-1:0] rs2,
        input logic              useRs1,
        input logic              useRs2
    );
        return exMemRead && (exRd != '0) &&
               ((useRs1 && (exRd == rs1)) || (useRs2 && (exRd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Wrapping event counter with synchronous active-low clear and count enable.
module hazard_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrN,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles, wrapping at 2^CNT_W; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!clrN) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flush and
// data-memory wait freeze for the 5-stage core.
// Optional macro HAZARD_PERF_CNT_EN adds stall/flush performance counters;
// without it both counter outputs are tied to zero.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic              if_id_use_rs1,
    input  logic              if_id_use_rs2,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              pipe_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Bubbles still owed after the first one of a hazard.
    localparam logic [2:0] BUBBLE_INIT = 3'(LOAD_STALL_CYC - 1);

    ctrlState_e state;
    ctrlState_e stateNext;
    logic [2:0] bubbleCnt;
    logic [2:0] bubbleCntNext;
    logic       luh;
    logic       memWait;

    assign luh = loadUseHazard(id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
                               if_id_use_rs1, if_id_use_rs2);

    // MEM_WAIT keeps holding until mem_ready even if mem_req is not re-asserted.
    assign memWait = (mem_req || (state == MEM_WAIT)) && !mem_ready;

    // State and owed-bubble count; reset overrides any stall or wait in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            bubbleCnt <= '0;
        end else begin
            state     <= stateNext;
            bubbleCnt <= bubbleCntNext;
        end
    end

    // Next state and enables, priority: memory wait > branch flush > load-use.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        pipe_hold     = 1'b0;
        stateNext     = state;
        bubbleCntNext = bubbleCnt;

        if (memWait) begin
            // Freeze everything; bubbleCnt is kept so an interrupted stall resumes.
            pipe_hold   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            stateNext   = MEM_WAIT;
        end else if (ex_branch_taken) begin
            // The stalled instruction is squashed, so any owed bubbles are dropped.
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            stateNext     = RUN;
            bubbleCntNext = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (luh) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_STALL_CYC > 1) begin
                            stateNext     = LOAD_STALL;
                            bubbleCntNext = BUBBLE_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (bubbleCnt <= 3'd1) begin
                        stateNext     = RUN;
                        bubbleCntNext = '0;
                    end else begin
                        bubbleCntNext = bubbleCnt - 3'd1;
                    end
                end
                MEM_WAIT: begin
                    stateNext = (bubbleCnt != '0) ? LOAD_STALL : RUN;
                end
                default: begin
                    stateNext     = RUN;
                    bubbleCntNext = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.CNT_W(CNT_W)) stallCounter (
        .clk   (clk),
        .clrN  (rst_n),
        .en    (!pc_write),
        .count (stall_cnt)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) flushCounter (
        .clk   (clk),
        .clrN  (rst_n),
        .en    (if_id_flush),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
